block_swap_dma: RTL
===================

Name: block_swap_dma

Overview:
- Small OBI manager that swaps two equal-length word blocks inside the SRAM banks (block-swapping support).
- Configured and polled through a regbus subordinate port hanging off the peripheral regbus demux.
- Its OBI manager port feeds one manager input of the main crossbar and uses the manager-side OBI request/response structs from croc_pkg.
- Raises a one-cycle interrupt on completion; the interrupt is routed as one of the NumExternalIrqs.

Parameters:
- MaxWords, 256, maximum LEN value accepted (words).
- UsableBase, croc_pkg FIRST_USABLE_SRAM_ADDR (0x1000_0800), lowest legal block address.
- SramEnd, SramBaseAddr+SramAddrRange (0x1000_1000), exclusive upper bound of legal addresses.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- reg_req_i  in  70  regbus request (reg_req_t)
- reg_rsp_o  out  34  regbus response (reg_rsp_t)
- obi_req_o  out  72  OBI manager request (mgr_obi_req_t)
- obi_rsp_i  in  37  OBI manager response (mgr_obi_rsp_t)
- irq_o  out  1  completion pulse

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values: all registers 0, FSM IDLE, obi req=0, irq_o=0.
- Register map, decoded on addr[11:0]:
  - 0x00 SRC_A (rw)
  - 0x04 SRC_B (rw)
  - 0x08 LEN (rw, words, 16 bits)
  - 0x0C CTRL (wo, bit0 start; reads as 0)
  - 0x10 STATUS (ro: bit0 busy, bit1 done, bit2 err)
- Regbus timing: ready=1 combinationally every cycle; rdata is combinational.
- Regbus errors (error=1, rdata=0, no side effect):
  - unmapped offset;
  - write to STATUS;
  - any write to SRC_A/SRC_B/LEN/CTRL while busy.
- Start (CTRL bit0 written with 1 in IDLE):
  - done and err are cleared.
  - Checks are evaluated in the same cycle, using 33-bit arithmetic.
- Start error conditions. Any of the following sets err=1 and done=1 in the next cycle, pulses irq_o, and issues no OBI request:
  - A or B not word aligned;
  - A < UsableBase or B < UsableBase;
  - A+4*LEN > SramEnd or B+4*LEN > SramEnd;
  - LEN > MaxWords;
  - ranges [A,A+4*LEN) and [B,B+4*LEN) overlap while LEN != 0.
- LEN=0 with otherwise valid addresses: done=1 next cycle, irq_o pulse, no OBI traffic.
- FSM states: IDLE, RD_A, RA_W, RD_B, RB_W, WR_B, WB_W, WR_A, WA_W. Word index i starts at 0.
  - RD_A: req with addr=A+4i, we=0; go to RA_W on gnt.
  - RA_W: on rvalid, latch bufA=rdata; go to RD_B.
  - RD_B / RB_W: same as RD_A / RA_W for B+4i, latching bufB.
  - WR_B: req with addr=B+4i, we=1, wdata=bufA; go to WB_W on gnt.
  - WB_W: on rvalid, go to WR_A.
  - WR_A: req with addr=A+4i, we=1, wdata=bufB; go to WA_W on gnt.
  - WA_W: on rvalid, i++. If i==LEN, go to IDLE with done=1 and irq_o pulse; else go to RD_A.
- OBI rules:
  - be=4'hF, aid=0, a_optional=0.
  - req stays high and the address channel stays stable until gnt.
  - req is low in all *_W states and IDLE, so at most one transaction is outstanding.
  - rvalid is only accepted in *_W states.
- Throughput: 4 transactions per word. With zero-wait gnt and rvalid one cycle later, one word takes 8 cycles.
- rvalid with err=1 in any *_W state:
  - abort to IDLE, err=1, done=1, irq_o pulse;
  - completed words remain swapped; the current word is left partially written if err occurs on WR_A.
- busy = (FSM != IDLE). irq_o is high exactly one cycle per start.
- Reset mid-transfer: FSM to IDLE and req=0 immediately (asynchronous); STATUS reads 0. The memory effect of the in-flight access is unspecified.
- Index width: i is 16 bits. No wrap is possible because LEN ≤ MaxWords is enforced.

Test Plan:
- Valid swap, zero-wait memory:
  - Stimulus: SRC_A=0x1000_0800 holds {0x11,0x22}; SRC_B=0x1000_0900 holds {0xAA,0xBB}; LEN=2; write CTRL=1.
  - Required response: A={0xAA,0xBB}, B={0x11,0x22}; STATUS=0x2; irq_o single pulse; exactly 8 OBI requests; completion 16 cycles after the first req.
- LEN=0:
  - Stimulus: LEN=0 with valid addresses, start.
  - Required response: STATUS=0x2 next cycle; irq pulse; obi req never high.
- Illegal base:
  - Stimulus: SRC_A=0x1000_0400, start.
  - Required response: STATUS=0x6; no OBI request.
- Overlap or out-of-range:
  - Stimulus: A=0x1000_0800, B=0x1000_0804, LEN=2.
  - Required response: STATUS=0x6.
  - Stimulus: A=0x1000_0FFC, LEN=2.
  - Required response: STATUS=0x6.
- Backpressure and bus error:
  - Stimulus: gnt delayed 3 cycles on every request.
  - Required response: addr/we/wdata stable until gnt.
  - Stimulus: rvalid err=1 on the first RD_B.
  - Required response: STATUS=0x6; memory at A and B unchanged.
- Busy protection and reset:
  - Stimulus: write SRC_A=0x1000_0C00 while busy.
  - Required response: reg error=1; SRC_A keeps its old value.
  - Stimulus: assert rst_ni=0 mid-transfer.
  - Required response: obi req drops in the same cycle; STATUS=0 after release.

Source files
------------

// File: rtl/block_swap_dma.sv
// Block-swap DMA: exchanges two equal-length word blocks in SRAM over an OBI manager port,
// configured through a regbus subordinate. Struct layouts follow croc_pkg reg_req_t/reg_rsp_t/mgr_obi_*_t.
//
// state | meaning
// IDLE  | waiting for start
// RD_A  | read request A+4i
// RA_W  | wait read data A, latch buf_a
// RD_B  | read request B+4i
// RB_W  | wait read data B, latch buf_b
// WR_B  | write buf_a to B+4i
// WB_W  | wait write response B
// WR_A  | write buf_b to A+4i
// WA_W  | wait write response A, advance index
module block_swap_dma #(
    parameter int unsigned MaxWords   = 256,
    parameter logic [31:0] UsableBase = 32'h1000_0800,
    parameter logic [31:0] SramEnd    = 32'h1000_1000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [69:0] reg_req_i,
    output logic [33:0] reg_rsp_o,
    output logic [71:0] obi_req_o,
    input  logic [36:0] obi_rsp_i,
    output logic        irq_o
);
    localparam logic [3:0] IDLE = 4'd0, RD_A = 4'd1, RA_W = 4'd2, RD_B = 4'd3, RB_W = 4'd4,
                           WR_B = 4'd5, WB_W = 4'd6, WR_A = 4'd7, WA_W = 4'd8;

    logic [31:0] reg_addr, reg_wdata;
    logic        reg_write, reg_valid;
    logic        gnt, rvalid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        unused_ok;

    assign reg_addr  = reg_req_i[69:38];
    assign reg_write = reg_req_i[37];
    assign reg_wdata = reg_req_i[36:5];
    assign reg_valid = reg_req_i[0];
    assign rsp_rdata = obi_rsp_i[36:5];
    assign rsp_err   = obi_rsp_i[3];
    assign gnt       = obi_rsp_i[1];
    assign rvalid    = obi_rsp_i[0];
    assign unused_ok = ^{reg_addr[31:12], reg_req_i[4:1], obi_rsp_i[4], obi_rsp_i[2]};

    logic [3:0]  state_q, state_d;
    logic [31:0] src_a_q, src_a_d, src_b_q, src_b_d, buf_a_q, buf_a_d, buf_b_q, buf_b_d;
    logic [15:0] len_q, len_d, idx_q, idx_d;
    logic        done_q, done_d, err_q, err_d, irq_q, irq_d;

    logic        busy, reg_err, we_src_a, we_src_b, we_len, start_req;
    logic [31:0] reg_rdata;

    assign busy = (state_q != IDLE);

    always_comb begin
        reg_rdata = '0;
        reg_err   = 1'b0;
        we_src_a  = 1'b0;
        we_src_b  = 1'b0;
        we_len    = 1'b0;
        start_req = 1'b0;
        if (reg_valid) begin
            case (reg_addr[11:0])
                12'h000: begin
                    reg_rdata = src_a_q;
                    if (reg_write) begin reg_err = busy; we_src_a = !busy; end
                end
                12'h004: begin
                    reg_rdata = src_b_q;
                    if (reg_write) begin reg_err = busy; we_src_b = !busy; end
                end
                12'h008: begin
                    reg_rdata = {16'b0, len_q};
                    if (reg_write) begin reg_err = busy; we_len = !busy; end
                end
                12'h00C: begin
                    if (reg_write) begin reg_err = busy; start_req = !busy && reg_wdata[0]; end
                end
                12'h010: begin
                    if (reg_write) reg_err = 1'b1;
                    else           reg_rdata = {29'b0, err_q, done_q, busy};
                end
                default: reg_err = 1'b1;
            endcase
        end
        if (reg_err) reg_rdata = '0;
    end

    assign reg_rsp_o = {reg_rdata, reg_err, 1'b1};

    // Legality checks in 33 bits so that A+4*LEN cannot wrap past 4 GiB
    logic [32:0] len_bytes, end_a, end_b;
    logic        cfg_bad;
    assign len_bytes = {15'b0, len_q, 2'b00};
    assign end_a     = {1'b0, src_a_q} + len_bytes;
    assign end_b     = {1'b0, src_b_q} + len_bytes;
    assign cfg_bad   = (src_a_q[1:0] != 2'b00) || (src_b_q[1:0] != 2'b00)
                    || (src_a_q < UsableBase) || (src_b_q < UsableBase)
                    || (end_a > {1'b0, SramEnd}) || (end_b > {1'b0, SramEnd})
                    || (len_q > 16'(MaxWords))
                    || ((len_q != 16'd0) && ({1'b0, src_a_q} < end_b) && ({1'b0, src_b_q} < end_a));

    logic [31:0] addr_a, addr_b, obi_addr, obi_wdata;
    logic        obi_req, obi_we;
    logic [15:0] idx_inc;
    assign addr_a  = src_a_q + {14'b0, idx_q, 2'b00};
    assign addr_b  = src_b_q + {14'b0, idx_q, 2'b00};
    assign idx_inc = idx_q + 16'd1;

    always_comb begin
        state_d   = state_q;
        src_a_d   = we_src_a ? reg_wdata : src_a_q;
        src_b_d   = we_src_b ? reg_wdata : src_b_q;
        len_d     = we_len ? reg_wdata[15:0] : len_q;
        idx_d     = idx_q;
        buf_a_d   = buf_a_q;
        buf_b_d   = buf_b_q;
        done_d    = done_q;
        err_d     = err_q;
        irq_d     = 1'b0;
        obi_req   = 1'b0;
        obi_we    = 1'b0;
        obi_addr  = '0;
        obi_wdata = '0;
        case (state_q)
            IDLE: if (start_req) begin
                done_d = 1'b0;
                err_d  = 1'b0;
                idx_d  = '0;
                if (cfg_bad) begin
                    done_d = 1'b1; err_d = 1'b1; irq_d = 1'b1;
                end else if (len_q == 16'd0) begin
                    done_d = 1'b1; irq_d = 1'b1;
                end else begin
                    state_d = RD_A;
                end
            end
            RD_A: begin
                obi_req = 1'b1; obi_addr = addr_a;
                if (gnt) state_d = RA_W;
            end
            RD_B: begin
                obi_req = 1'b1; obi_addr = addr_b;
                if (gnt) state_d = RB_W;
            end
            WR_B: begin
                obi_req = 1'b1; obi_we = 1'b1; obi_addr = addr_b; obi_wdata = buf_a_q;
                if (gnt) state_d = WB_W;
            end
            WR_A: begin
                obi_req = 1'b1; obi_we = 1'b1; obi_addr = addr_a; obi_wdata = buf_b_q;
                if (gnt) state_d = WA_W;
            end
            RA_W, RB_W, WB_W, WA_W: if (rvalid) begin
                if (rsp_err) begin
                    state_d = IDLE; err_d = 1'b1; done_d = 1'b1; irq_d = 1'b1;
                end else begin
                    case (state_q)
                        RA_W:    begin buf_a_d = rsp_rdata; state_d = RD_B; end
                        RB_W:    begin buf_b_d = rsp_rdata; state_d = WR_B; end
                        WB_W:    state_d = WR_A;
                        default: begin
                            idx_d = idx_inc;
                            if (idx_inc == len_q) begin
                                state_d = IDLE; done_d = 1'b1; irq_d = 1'b1;
                            end else begin
                                state_d = RD_A;
                            end
                        end
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign obi_req_o = {obi_addr, obi_we, 4'hF, obi_wdata, 1'b0, 1'b0, obi_req};
    assign irq_o     = irq_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            src_a_q <= '0;
            src_b_q <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            buf_a_q <= '0;
            buf_b_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_a_q <= src_a_d;
            src_b_q <= src_b_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            buf_a_q <= buf_a_d;
            buf_b_q <= buf_b_d;
            done_q  <= done_d;
            err_q   <= err_d;
            irq_q   <= irq_d;
        end
    end
endmodule
